// File: rtl/apb_i2c_slave_regs.sv
// APB front end for the I2C bridge: TX/RX FIFO windows plus control, status,
// slave-address and prescale registers, with FIFO wait states and a stall timeout.
module apb_i2c_slave_regs #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] APB_RX,
  input  logic                  WRITE_FULL,
  input  logic                  READ_EMPTY,
  output logic                  W_ENA,
  output logic                  R_ENA,
  output logic [DATA_WIDTH-1:0] APB_TX,
  input  logic                  I2C_BUSY,
  input  logic                  I2C_NACK,
  output logic                  CTRL_EN,
  output logic                  START,
  output logic                  STOP,
  output logic                  RW_BIT,
  output logic [6:0]            SLAVE_ADDR,
  output logic [DATA_WIDTH-1:0] PRESCALE
);

  localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_TXDATA = ADDR_WIDTH'('h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RXDATA = ADDR_WIDTH'('h04);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'('h08);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'('h0C);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SADDR  = ADDR_WIDTH'('h10);
  localparam logic [ADDR_WIDTH-1:0] ADDR_PRESC  = ADDR_WIDTH'('h14);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state, state_next;

  // Transfer captured during SETUP
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CNT_W-1:0]      wait_cnt;

  // Register file
  logic                  ctrl_en_q;
  logic                  rw_bit_q;
  logic                  start_q;
  logic                  stop_q;
  logic [6:0]            slave_addr_q;
  logic [DATA_WIDTH-1:0] prescale_q;
  logic                  nack_sticky;

  logic hit_tx, hit_rx, hit_ctrl, hit_status, hit_saddr, hit_presc;
  logic addr_valid, fifo_target, fifo_ready, at_limit;
  logic complete, xfer_err, reg_write;
  logic [DATA_WIDTH-1:0] read_mux;

  assign hit_tx     = (addr_q == ADDR_TXDATA);
  assign hit_rx     = (addr_q == ADDR_RXDATA);
  assign hit_ctrl   = (addr_q == ADDR_CTRL);
  assign hit_status = (addr_q == ADDR_STATUS);
  assign hit_saddr  = (addr_q == ADDR_SADDR);
  assign hit_presc  = (addr_q == ADDR_PRESC);
  assign addr_valid = hit_tx | hit_rx | hit_ctrl | hit_status | hit_saddr | hit_presc;

  // Only the FIFO windows can stall; a wrong-direction FIFO access never becomes
  // ready and therefore ends through the timeout with an error.
  assign fifo_target = hit_tx | hit_rx;
  assign fifo_ready  = (hit_tx & write_q & ~WRITE_FULL) | (hit_rx & ~write_q & ~READ_EMPTY);
  assign at_limit    = (wait_cnt == CNT_LAST);

  always_comb begin
    read_mux = '0;
    if (hit_rx)          read_mux      = APB_RX;
    else if (hit_ctrl)   read_mux[3:0] = {rw_bit_q, 2'b00, ctrl_en_q};
    else if (hit_status) read_mux[3:0] = {nack_sticky, I2C_BUSY, READ_EMPTY, WRITE_FULL};
    else if (hit_saddr)  read_mux[6:0] = slave_addr_q;
    else if (hit_presc)  read_mux      = prescale_q;
  end

  always_ff @(posedge PCLK) begin
    // NOTE: registers update with <= so every flop samples pre-edge values,
    // independent of the order the always blocks are evaluated in.
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_next = state;
    complete   = 1'b0;
    xfer_err   = 1'b0;
    reg_write  = 1'b0;
    PRDATA     = '0;
    W_ENA      = 1'b0;
    R_ENA      = 1'b0;
    case (state)
      IDLE: begin
        if (PSELx && !PENABLE) state_next = SETUP;
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        // Reset cycles suppress completion so a dropped transfer leaves no trace.
        complete = !PRESET && (!fifo_target || fifo_ready || at_limit);
        if (complete) begin
          xfer_err   = !addr_valid || (fifo_target && !fifo_ready);
          state_next = (PSELx && !PENABLE) ? SETUP : IDLE;
          if (!xfer_err) begin
            if (write_q) begin
              W_ENA     = hit_tx;
              reg_write = 1'b1;
            end else begin
              R_ENA  = hit_rx;
              PRDATA = read_mux;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign PREADY  = complete;
  assign PSLVERR = xfer_err;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == SETUP) begin
        addr_q   <= PADDR;
        write_q  <= PWRITE;
        wdata_q  <= PWDATA;
        wait_cnt <= '0;
      end else if (state == ACCESS && !complete) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_en_q    <= 1'b0;
      rw_bit_q     <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      slave_addr_q <= '0;
      prescale_q   <= '0;
      nack_sticky  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      if (reg_write && hit_ctrl) begin
        ctrl_en_q <= wdata_q[0];
        start_q   <= wdata_q[1];
        stop_q    <= wdata_q[2];
        rw_bit_q  <= wdata_q[3];
      end
      if (reg_write && hit_saddr) slave_addr_q <= wdata_q[6:0];
      if (reg_write && hit_presc) prescale_q   <= wdata_q;
      // A NACK arriving in the same cycle as a W1C clear keeps the flag set.
      nack_sticky <= I2C_NACK | (nack_sticky & ~(reg_write & hit_status & wdata_q[3]));
    end
  end

  assign APB_TX     = wdata_q;
  assign CTRL_EN    = ctrl_en_q;
  assign START      = start_q;
  assign STOP       = stop_q;
  assign RW_BIT     = rw_bit_q;
  assign SLAVE_ADDR = slave_addr_q;
  assign PRESCALE   = prescale_q;

endmodule

// File: tb/tb_apb_i2c_slave_regs.sv
// Self-checking bench for apb_i2c_slave_regs: a transfer-level register model
// compared every cycle, plus directed transfers with literal expectations.
module tb_apb_i2c_slave_regs;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int WT = 16;

  logic          PCLK = 1'b0;
  logic          PRESET, PSELx, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA, APB_RX, APB_TX, PRESCALE;
  logic          PREADY, PSLVERR, WRITE_FULL, READ_EMPTY, W_ENA, R_ENA;
  logic          I2C_BUSY, I2C_NACK, CTRL_EN, START, STOP, RW_BIT;
  logic [6:0]    SLAVE_ADDR;

  int vectors = 0;
  int miscompares = 0;
  int w_pulses = 0, r_pulses = 0, start_pulses = 0, stop_pulses = 0;

  apb_i2c_slave_regs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_TIMEOUT(WT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .APB_RX(APB_RX), .WRITE_FULL(WRITE_FULL), .READ_EMPTY(READ_EMPTY),
    .W_ENA(W_ENA), .R_ENA(R_ENA), .APB_TX(APB_TX), .I2C_BUSY(I2C_BUSY),
    .I2C_NACK(I2C_NACK), .CTRL_EN(CTRL_EN), .START(START), .STOP(STOP),
    .RW_BIT(RW_BIT), .SLAVE_ADDR(SLAVE_ADDR), .PRESCALE(PRESCALE)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: register contents plus the age of the transfer in flight
  // (-1 none, 0 setup cycle, n>=1 the n-th access cycle).
  logic       m_ctrl_en = 0, m_rw = 0, m_nack = 0, m_start = 0, m_stop = 0;
  logic [6:0] m_saddr = 0;
  logic [7:0] m_presc = 0;
  logic [7:0] x_addr = 0, x_wdata = 0;
  logic       x_write = 0;
  logic       after_reset = 0;
  int         age = -1;

  always @(negedge PCLK) begin : model_cmp
    logic       e_ready, e_err, e_wen, e_ren, fifo, fifo_ok, valid, clr;
    logic [7:0] e_rdata;
    if (W_ENA) w_pulses++;
    if (R_ENA) r_pulses++;
    if (START) start_pulses++;
    if (STOP)  stop_pulses++;
    if (PRESET) begin
      check("pready_in_reset", PREADY, 0);
      check("w_ena_in_reset", W_ENA, 0);
      check("r_ena_in_reset", R_ENA, 0);
      m_ctrl_en = 0; m_rw = 0; m_nack = 0; m_start = 0; m_stop = 0;
      m_saddr = 0; m_presc = 0; x_addr = 0; x_wdata = 0; x_write = 0;
      age = -1;
      after_reset = 1;
    end else begin
      e_ready = 0; e_err = 0; e_wen = 0; e_ren = 0; e_rdata = 0;
      if (age >= 1) begin
        valid   = x_addr inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
        fifo    = (x_addr == 8'h00) || (x_addr == 8'h04);
        fifo_ok = (x_addr == 8'h00 && x_write && !WRITE_FULL) ||
                  (x_addr == 8'h04 && !x_write && !READ_EMPTY);
        e_ready = !fifo || fifo_ok || (age == WT);
        if (e_ready) begin
          e_err = !valid || (fifo && !fifo_ok);
          if (!e_err && x_write && x_addr == 8'h00) e_wen = 1;
          if (!e_err && !x_write) begin
            case (x_addr)
              8'h04: begin e_rdata = APB_RX; e_ren = 1; end
              8'h08: e_rdata = {4'b0, m_rw, 2'b00, m_ctrl_en};
              8'h0C: e_rdata = {4'b0, m_nack, I2C_BUSY, READ_EMPTY, WRITE_FULL};
              8'h10: e_rdata = {1'b0, m_saddr};
              8'h14: e_rdata = m_presc;
              default: e_rdata = 0;
            endcase
          end
        end
      end
      check("pready", PREADY, e_ready);
      check("w_ena", W_ENA, e_wen);
      check("r_ena", R_ENA, e_ren);
      check("ctrl_en", CTRL_EN, m_ctrl_en);
      check("rw_bit", RW_BIT, m_rw);
      check("start", START, m_start);
      check("stop", STOP, m_stop);
      check("slave_addr", SLAVE_ADDR, m_saddr);
      check("prescale", PRESCALE, m_presc);
      if (e_ready || after_reset) begin
        check("pslverr", PSLVERR, e_err);
        check("prdata", PRDATA, e_rdata);
      end
      if (e_wen || after_reset) check("apb_tx", APB_TX, e_wen ? x_wdata : 8'h00);
      after_reset = 0;

      // Advance to the next cycle.
      m_start = 0; m_stop = 0; clr = 0;
      if (e_ready && !e_err && x_write) begin
        case (x_addr)
          8'h08: begin
            m_ctrl_en = x_wdata[0]; m_start = x_wdata[1];
            m_stop = x_wdata[2]; m_rw = x_wdata[3];
          end
          8'h0C: clr = x_wdata[3];
          8'h10: m_saddr = x_wdata[6:0];
          8'h14: m_presc = x_wdata;
          default: ;
        endcase
      end
      m_nack = I2C_NACK || (m_nack && !clr);
      if (age == -1) begin
        if (PSELx && !PENABLE) age = 0;
      end else if (age == 0) begin
        x_addr = PADDR; x_write = PWRITE; x_wdata = PWDATA;
        age = 1;
      end else if (e_ready) begin
        age = (PSELx && !PENABLE) ? 0 : -1;
      end else begin
        age++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // One APB transfer; optionally clears both FIFO flags after release_after
  // stalled access cycles. acc reports the access cycle on which PREADY rose.
  task automatic apb_xfer(input logic [7:0] addr, input logic wr, input logic [7:0] wd,
                          input int release_after, output logic [7:0] rd,
                          output logic er, output int acc);
    logic done;
    tick(1);
    PSELx = 1; PENABLE = 0; PADDR = addr; PWRITE = wr; PWDATA = wd;
    tick(1);
    PENABLE = 1;
    tick(1);
    acc = 0; done = 0; rd = 0; er = 0;
    while (!done && acc < 64) begin
      @(negedge PCLK);
      acc++;
      if (PREADY) begin
        rd = PRDATA; er = PSLVERR; done = 1;
      end else begin
        tick(1);
        if (acc == release_after) begin
          READ_EMPTY = 0; WRITE_FULL = 0;
        end
      end
    end
    check("xfer_done", done, 1);
    tick(1);
    PSELx = 0; PENABLE = 0;
  endtask

  logic [7:0] rd;
  logic       er;
  int         acc, w0, r0, s0;

  initial begin
    PRESET = 1; PSELx = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    APB_RX = 0; WRITE_FULL = 0; READ_EMPTY = 0; I2C_BUSY = 0; I2C_NACK = 0;
    tick(3);
    PRESET = 0;
    @(negedge PCLK);
    check("lit_rst_pready", PREADY, 0);
    check("lit_rst_prescale", PRESCALE, 0);
    check("lit_rst_saddr", SLAVE_ADDR, 0);

    // Zero-wait TXDATA write
    w0 = w_pulses;
    apb_xfer(8'h00, 1, 8'h55, -1, rd, er, acc);
    check("lit_tx_acc", acc, 1);
    check("lit_tx_err", er, 0);
    check("lit_tx_wpulse", w_pulses - w0, 1);

    // RXDATA read stalled for 3 access cycles
    APB_RX = 8'h55; READ_EMPTY = 1; r0 = r_pulses;
    apb_xfer(8'h04, 0, 8'h00, 3, rd, er, acc);
    check("lit_rx_acc", acc, 4);
    check("lit_rx_data", rd, 8'h55);
    check("lit_rx_err", er, 0);
    check("lit_rx_rpulse", r_pulses - r0, 1);

    // TXDATA write against a full FIFO times out
    WRITE_FULL = 1; w0 = w_pulses;
    apb_xfer(8'h00, 1, 8'h77, -1, rd, er, acc);
    check("lit_to_acc", acc, WT);
    check("lit_to_err", er, 1);
    check("lit_to_wpulse", w_pulses - w0, 0);
    WRITE_FULL = 0;

    // CTRL: enable, start, read direction
    s0 = start_pulses;
    apb_xfer(8'h08, 1, 8'h0B, -1, rd, er, acc);
    tick(2);
    check("lit_ctrl_start", start_pulses - s0, 1);
    check("lit_ctrl_en", CTRL_EN, 1);
    check("lit_ctrl_rw", RW_BIT, 1);
    apb_xfer(8'h08, 0, 8'h00, -1, rd, er, acc);
    check("lit_ctrl_read", rd, 8'h09);
    s0 = stop_pulses;
    apb_xfer(8'h08, 1, 8'h05, -1, rd, er, acc);
    tick(2);
    check("lit_ctrl_stop", stop_pulses - s0, 1);
    check("lit_ctrl_rw0", RW_BIT, 0);

    // STATUS: live flags, sticky NACK, W1C and set-wins
    I2C_BUSY = 1; READ_EMPTY = 1;
    I2C_NACK = 1; tick(1); I2C_NACK = 0;
    apb_xfer(8'h0C, 0, 8'h00, -1, rd, er, acc);
    check("lit_stat_nack", rd, 8'h0E);
    apb_xfer(8'h0C, 1, 8'h08, -1, rd, er, acc);
    apb_xfer(8'h0C, 0, 8'h00, -1, rd, er, acc);
    check("lit_stat_clr", rd, 8'h06);
    I2C_NACK = 1;
    apb_xfer(8'h0C, 1, 8'h08, -1, rd, er, acc);
    I2C_NACK = 0;
    apb_xfer(8'h0C, 0, 8'h00, -1, rd, er, acc);
    check("lit_stat_setwins", rd, 8'h0E);
    apb_xfer(8'h0C, 1, 8'h08, -1, rd, er, acc);

    // Bad addresses
    apb_xfer(8'h20, 0, 8'h00, -1, rd, er, acc);
    check("lit_bad_err", er, 1);
    check("lit_bad_data", rd, 8'h00);
    check("lit_bad_acc", acc, 1);
    apb_xfer(8'h11, 1, 8'hFF, -1, rd, er, acc);
    check("lit_unaligned_err", er, 1);

    // SADDR truncates to 7 bits; PRESC full width
    apb_xfer(8'h10, 1, 8'hFF, -1, rd, er, acc);
    apb_xfer(8'h10, 0, 8'h00, -1, rd, er, acc);
    check("lit_saddr", rd, 8'h7F);
    apb_xfer(8'h14, 1, 8'hA5, -1, rd, er, acc);
    apb_xfer(8'h14, 0, 8'h00, -1, rd, er, acc);
    check("lit_presc", rd, 8'hA5);

    // Reset in the middle of a stalled RXDATA read
    I2C_NACK = 1; tick(1); I2C_NACK = 0;
    READ_EMPTY = 1; r0 = r_pulses;
    tick(1);
    PSELx = 1; PENABLE = 0; PADDR = 8'h04; PWRITE = 0;
    tick(1);
    PENABLE = 1;
    tick(3);
    PRESET = 1;
    tick(1);
    PRESET = 0; PSELx = 0; PENABLE = 0;
    @(negedge PCLK);
    check("lit_mid_pready", PREADY, 0);
    check("lit_mid_ctrl_en", CTRL_EN, 0);
    check("lit_mid_saddr", SLAVE_ADDR, 0);
    check("lit_mid_presc", PRESCALE, 0);
    check("lit_mid_rpulse", r_pulses - r0, 0);
    READ_EMPTY = 0; APB_RX = 8'h3C;
    apb_xfer(8'h04, 0, 8'h00, -1, rd, er, acc);
    check("lit_post_rx", rd, 8'h3C);
    check("lit_post_acc", acc, 1);
    check("lit_post_err", er, 0);
    apb_xfer(8'h0C, 0, 8'h00, -1, rd, er, acc);
    check("lit_post_status", rd, 8'h04);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_i2c_slave_regs.md
Name: apb_i2c_slave_regs

Overview:
Parametrised APB slave that is the next generation of the I2C-APB bridge front end. It keeps the TX/RX FIFO data path (W_ENA/APB_TX, R_ENA/APB_RX). It adds a register map for I2C control, status, slave address and prescale. It inserts wait states on FIFO full/empty, ends stalled transfers with a timeout and PSLVERR, and flags bad addresses with PSLVERR. It sits between the system APB bus and the I2C FIFOs and master core.

Parameters:
DATA_WIDTH, 8, width of PWDATA/PRDATA/APB_TX/APB_RX/PRESCALE.
ADDR_WIDTH, 8, width of PADDR.
WAIT_TIMEOUT, 16, maximum stalled ACCESS cycles before forced error completion (≥1).

Ports:
PCLK  in  1  system clock, all logic on rising edge.
PRESET  in  1  synchronous reset, active-high.
PSELx  in  1  APB select.
PENABLE  in  1  APB enable (access phase).
PWRITE  in  1  1 = write, 0 = read.
PADDR  in  ADDR_WIDTH  register address.
PWDATA  in  DATA_WIDTH  write data.
PREADY  out  1  transfer complete.
PRDATA  out  DATA_WIDTH  read data, valid when PREADY=1.
PSLVERR  out  1  error, valid only when PREADY=1.
APB_RX  in  DATA_WIDTH  RX FIFO head (show-ahead).
WRITE_FULL  in  1  TX FIFO full.
READ_EMPTY  in  1  RX FIFO empty.
W_ENA  out  1  TX FIFO push strobe.
R_ENA  out  1  RX FIFO pop strobe.
APB_TX  out  DATA_WIDTH  TX FIFO write data.
I2C_BUSY  in  1  I2C core busy.
I2C_NACK  in  1  I2C core NACK pulse.
CTRL_EN  out  1  I2C core enable.
START  out  1  one-cycle start pulse.
STOP  out  1  one-cycle stop pulse.
RW_BIT  out  1  I2C direction bit.
SLAVE_ADDR  out  7  I2C target address.
PRESCALE  out  DATA_WIDTH  SCL divider.

Behaviour:
- Register map (byte addresses): 0x00 TXDATA (W), 0x04 RXDATA (R), 0x08 CTRL (R/W), 0x0C STATUS (R, W1C), 0x10 SADDR (R/W), 0x14 PRESC (R/W). Any other address gives PSLVERR=1 on completion, has no side effect, and returns PRDATA=0.
- CTRL: bit0 CTRL_EN, bit1 START, bit2 STOP, bit3 RW_BIT.
  - Writing START/STOP = 1 produces a single-cycle pulse on the cycle after the completing access. These bits always read back as 0.
- STATUS: bit0 WRITE_FULL, bit1 READ_EMPTY, bit2 I2C_BUSY (these are live), bit3 NACK_STICKY (set by I2C_NACK, cleared by writing 1). If a set and a clear occur in the same cycle, set wins.
- FSM states IDLE, SETUP, ACCESS.
  - IDLE→SETUP when PSELx=1 and PENABLE=0.
  - SETUP→ACCESS unconditionally. PADDR, PWRITE and PWDATA are latched in SETUP.
  - ACCESS→IDLE when PREADY=1. If PSELx=1 and PENABLE=0 in that cycle, go to SETUP instead (back-to-back transfer).
  - PENABLE=1 while in IDLE is a protocol error and is ignored.
- PREADY (combinational from state, latched address and FIFO flags) is 1 in ACCESS when any of these holds:
  - the target is not TXDATA/RXDATA;
  - a TXDATA write with WRITE_FULL=0;
  - an RXDATA read with READ_EMPTY=0;
  - the wait counter = WAIT_TIMEOUT−1.
- Wait counter: cleared in SETUP, increments each stalled ACCESS cycle. A timeout completion gives PSLVERR=1, no FIFO strobe, and PRDATA=0.
- W_ENA=1 only in the completing ACCESS cycle of a successful TXDATA write, with APB_TX = latched PWDATA. R_ENA=1 only in the completing cycle of a successful RXDATA read, with PRDATA=APB_RX. Each strobe lasts exactly one cycle per transfer.
- Read of a write-only or write to a read-only register: PSLVERR=1, no side effect.
- Register writes take effect on the edge ending the completing ACCESS cycle.
- Reset (PRESET=1, any state, including mid-transfer): state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, W_ENA=0, R_ENA=0, APB_TX=0, CTRL_EN=0, START=0, STOP=0, RW_BIT=0, SLAVE_ADDR=0, PRESCALE=0, NACK_STICKY=0, counter 0. An interrupted transfer is dropped with no strobes.
- Zero-wait transfer latency: 2 cycles (SETUP + ACCESS).

Test Plan:
- Write 0x55 to 0x00 with WRITE_FULL=0 → PREADY=1 in the first ACCESS cycle, W_ENA pulses 1 cycle, APB_TX=0x55, PSLVERR=0.
- Read 0x04 with APB_RX=0x55, READ_EMPTY=1 for 3 cycles then 0 → PREADY low 3 ACCESS cycles, then PREADY=1, PRDATA=0x55, R_ENA pulses once.
- Write to 0x00 with WRITE_FULL held 1 → after 16 ACCESS cycles PREADY=1, PSLVERR=1, W_ENA never asserted.
- Write 0x0B to 0x08 → CTRL_EN=1, RW_BIT=1, START pulses exactly 1 cycle; read 0x08 → 0x09.
- Pulse I2C_NACK, read 0x0C → bit3=1; write 0x08 to 0x0C → bit3 clears; read 0x20 → PSLVERR=1, PRDATA=0.
- Assert PRESET during a stalled RXDATA read → next cycle all outputs at reset values, R_ENA not asserted, and a new transfer completes normally.
